ram_io_responder: RTL and testbench
===================================

// Module: ram_io_responder
// PURPOSE
//  RAM-side responder for the byte-serial memory bus driven by the memory controller.
//  Serves one byte per cycle from a single-port RAM with a fixed 1-cycle read latency.
//  Decodes the memory-mapped IO window: UART TX byte FIFO, optional UART RX byte, and a halt register.
//  Drives uart_full back to the controller so it stalls IO stores.
// PARAMETERS
//  ADDR_WIDTH     17        RAM index width; RAM size = 2**ADDR_WIDTH bytes
//  TX_FIFO_DEPTH  8         UART TX FIFO entries; power of two, >= 4
//  IO_ADDR        32'h30000 UART data register; halt register at IO_ADDR+4
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, asynchronous, active-low
//  rdy             in   1   global enable; low freezes all state
//  addr_to_ram     in   32  byte address from controller, sampled every cycle
//  data_to_ram     in   8   store byte
//  load_store_sign in   1   `RAM_LOAD (0) / `RAM_STORE (1)
//  data_from_ram   out  8   read byte, registered
//  uart_full_sign  out  1   TX FIFO near-full; controller must not issue IO stores
//  tx_valid        out  1   TX FIFO head valid
//  tx_data         out  8   TX FIFO head byte
//  tx_ready        in   1   sink accepts head when tx_valid && tx_ready
//  rx_valid        in   1   host offers an RX byte (used only with IO_RX_EN)
//  rx_data         in   8   RX byte
//  rx_ready        out  1   RX holding register empty
//  halt            out  1   sticky; set by any store to IO_ADDR+4
// BEHAVIOUR
//  - Reset (rst=0, async): data_from_ram=0, tx_valid=0, FIFO count=0, rx holding empty, halt=0, uart_full_sign=0. RAM contents are not reset.
//  - rdy=0: no state changes; data_from_ram holds its value; a pending TX handshake is not consumed.
//  - Decode: io = (addr[17:16]==2'b11); RAM index = addr[ADDR_WIDTH-1:0].
//  - Load, cycle N: data_from_ram = mem[idx] (or the IO value) at N+1. Every cycle is a new access; there is no handshake.
//  - Store to RAM at cycle N: mem[idx] <= data_to_ram. A load of the same idx at N+1 returns the new byte.
//  - Load of an IO address at cycle N: data_from_ram = 8'h00 at N+1, except as defined by IO_RX_EN.
//  - Store to IO_ADDR: push data_to_ram to the TX FIFO. If the FIFO is full, drop the byte; the controller contract makes this unreachable.
//  - Store to IO_ADDR+4: halt <= 1. Stores to other IO addresses are ignored.
//  - uart_full_sign is combinational: (count >= TX_FIFO_DEPTH-1). The 1-slot slack covers the controller's registered issue.
//  - Push and pop in the same cycle: count unchanged. Push at count==DEPTH-1 is accepted. Pop at count==0 is impossible (tx_valid=0).
//  - Pointers are log2(DEPTH) bits and wrap. count is log2(DEPTH)+1 bits.
//  - tx_valid = (count!=0). tx_data = head byte, stable until popped.
// CONFIGURATION
//  IO_RX_EN defined:
//   - rx_ready = holding empty.
//   - rx_valid && rx_ready captures rx_data.
//   - A load of IO_ADDR returns the held byte and empties the holding register. If empty, it returns 8'h00.
//   - A capture and a read in the same cycle: the read returns the old value (8'h00 if empty); the new byte is held.
//  IO_RX_EN undefined: rx_ready=0; rx_valid and rx_data are ignored; IO loads return 8'h00.
// STRUCTURE
//  - defines.v: `RAM_LOAD/`RAM_STORE, `RAM_IO_ADDR, `MEMDATA_TYPE, `ADDR_TYPE.
//  - Sub-module byte_fifo (depth param, push/pop/count/full/empty) implements the TX FIFO.
//  - RAM is an inferred reg array in this module.
// TESTING
//  - Store 8'hA5 @0x100, then load 0x100 next cycle -> data_from_ram=8'hA5 one cycle after the load.
//  - Store 0x11..0x17 to IO_ADDR with tx_ready=0 -> uart_full_sign=1 after the 7th push; tx_data=0x11.
//  - FIFO full, then tx_ready=1 for 1 cycle concurrent with a push -> count stays 8; order preserved.
//  - Hold 4 pushes, pulse rdy=0 for 3 cycles with tx_ready=1 -> no pops or state change while frozen.
//  - Store to IO_ADDR+4 -> halt=1. Assert rst=0 mid-FIFO-drain -> tx_valid=0, halt=0 immediately.
//  - IO_RX_EN: rx_valid with 0x42, then load IO_ADDR -> 0x42, rx_ready=1; a second load -> 0x00.

Source files
------------

// File: rtl/ram_io_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_io_responder_pkg
// Purpose  : Shared types and constants for the RAM/IO responder of the
//            byte-serial memory bus.
// Revision : 1.0 - initial release
// ============================================================================
package ram_io_responder_pkg;

    typedef enum logic {
        RAM_LOAD  = 1'b0,
        RAM_STORE = 1'b1
    } ram_op_e;

    typedef logic [7:0]  memdata_t;
    typedef logic [31:0] addr_t;

    localparam addr_t      c_ram_io_addr = 32'h0003_0000;
    localparam logic [1:0] c_io_sel      = 2'b11;

    // The IO window occupies the top quarter of the 18-bit bus space.
    function automatic logic is_io(input addr_t a);
        return a[17:16] == c_io_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_io_responder_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ram_io_responder_byte_fifo
// Purpose  : Byte FIFO with wrapping pointers and an occupancy counter.
//            Used as the UART TX queue.
// Revision : 1.0 - initial release
// ============================================================================
module ram_io_responder_byte_fifo #(
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [7:0]       r_mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // A push into a full FIFO is taken only when the head leaves in the same cycle.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/ram_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : ram_io_responder
// Purpose  : RAM-side responder: 1-cycle-latency byte RAM plus IO window
//            (UART TX FIFO, halt register, optional UART RX byte).
//            Build option: define IO_RX_EN to enable the UART RX holding byte.
// Revision : 1.0 - initial release
// ============================================================================
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH    = 17,
    parameter int          TX_FIFO_DEPTH = 8,
    parameter logic [31:0] IO_ADDR       = c_ram_io_addr
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] addr_to_ram,
    input  logic [7:0]  data_to_ram,
    input  logic        load_store_sign,
    output logic [7:0]  data_from_ram,
    output logic        uart_full_sign,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        halt
);

    localparam int                 c_cnt_w     = $clog2(TX_FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_near_full = c_cnt_w'(TX_FIFO_DEPTH - 1);
    localparam logic [31:0]        c_halt_addr = IO_ADDR + 32'd4;

    logic [7:0]            r_mem [0:(2**ADDR_WIDTH)-1];
    logic [7:0]            r_data_from_ram;
    logic                  r_halt;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_is_io;
    logic                  w_is_store;
    logic                  w_is_load;
    logic                  w_uart_hit;
    logic                  w_tx_push;
    logic                  w_tx_pop;
    logic [7:0]            w_io_rdata;
    logic [c_cnt_w-1:0]    w_tx_count;
    logic                  w_tx_full;
    logic                  w_tx_empty;
    logic                  w_unused_fifo;

    assign w_idx      = addr_to_ram[ADDR_WIDTH-1:0];
    assign w_is_io    = is_io(addr_to_ram);
    assign w_is_store = (ram_op_e'(load_store_sign) == RAM_STORE);
    assign w_is_load  = !w_is_store;
    assign w_uart_hit = (addr_to_ram == IO_ADDR);

    // All state advances only while rdy is high, including the TX handshake.
    assign w_tx_push  = rdy && w_is_store && w_uart_hit;
    assign w_tx_pop   = rdy && tx_ready;

    ram_io_responder_byte_fifo #(
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_tx_push),
        .push_data (data_to_ram),
        .pop       (w_tx_pop),
        .head_data (tx_data),
        .count     (w_tx_count),
        .full      (w_tx_full),
        .empty     (w_tx_empty)
    );

    assign w_unused_fifo  = w_tx_full;
    assign tx_valid       = !w_tx_empty;
    assign uart_full_sign = (w_tx_count >= c_near_full);

`ifdef IO_RX_EN
    logic       r_rx_full;
    logic [7:0] r_rx_data;
    logic       w_rx_capture;
    logic       w_rx_read;

    assign rx_ready     = !r_rx_full;
    assign w_rx_capture = rdy && rx_valid && !r_rx_full;
    assign w_rx_read    = rdy && w_is_load && w_uart_hit;
    assign w_io_rdata   = (w_uart_hit && r_rx_full) ? r_rx_data : 8'h00;

    // Capture only happens when empty, so a same-cycle read sees 0 and the new byte stays held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_full <= 1'b0;
            r_rx_data <= 8'h00;
        end else if (w_rx_capture) begin
            r_rx_full <= 1'b1;
            r_rx_data <= rx_data;
        end else if (w_rx_read) begin
            r_rx_full <= 1'b0;
        end
    end
`else
    logic w_unused_rx;

    assign rx_ready    = 1'b0;
    assign w_io_rdata  = 8'h00;
    assign w_unused_rx = ^{rx_valid, rx_data};
`endif

    always_ff @(posedge clk) begin
        if (rdy && w_is_store && !w_is_io) r_mem[w_idx] <= data_to_ram;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_from_ram <= 8'h00;
        end else if (rdy && w_is_load) begin
            r_data_from_ram <= w_is_io ? w_io_rdata : r_mem[w_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halt <= 1'b0;
        end else if (rdy && w_is_store && (addr_to_ram == c_halt_addr)) begin
            r_halt <= 1'b1;
        end
    end

    assign data_from_ram = r_data_from_ram;
    assign halt          = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_ram_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_io_responder
// Purpose  : Directed self-checking bench for ram_io_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_io_responder;

    localparam logic [31:0] c_io = 32'h0003_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] addr_to_ram;
    logic [7:0]  data_to_ram;
    logic        load_store_sign;
    logic [7:0]  data_from_ram;
    logic        uart_full_sign;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        halt;

    int n_checks = 0;
    int n_pass   = 0;

    ram_io_responder dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .addr_to_ram     (addr_to_ram),
        .data_to_ram     (data_to_ram),
        .load_store_sign (load_store_sign),
        .data_from_ram   (data_from_ram),
        .uart_full_sign  (uart_full_sign),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .rx_ready        (rx_ready),
        .halt            (halt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Apply one bus operation for one clock; returns 1 time unit after the edge.
    task automatic op(input logic st, input logic [31:0] a, input logic [7:0] d);
        load_store_sign = st;
        addr_to_ram     = a;
        data_to_ram     = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; addr_to_ram = '0; data_to_ram = '0;
        load_store_sign = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data",  {24'h0, data_from_ram}, 32'h00);
        check("rst_txv",   {31'h0, tx_valid},       32'h0);
        check("rst_full",  {31'h0, uart_full_sign}, 32'h0);
        check("rst_halt",  {31'h0, halt},           32'h0);
`ifdef IO_RX_EN
        check("rst_rxrdy", {31'h0, rx_ready},       32'h1);
`else
        check("rst_rxrdy", {31'h0, rx_ready},       32'h0);
`endif
        rst = 1'b1;

        // RAM store/load
        op(1'b1, 32'h0000_0000, 8'hC3);
        op(1'b1, 32'h0000_0100, 8'hA5);
        op(1'b0, 32'h0000_0100, 8'h00);
        check("ram_rd_100", {24'h0, data_from_ram}, 32'hA5);
        op(1'b1, 32'h0001_FFFF, 8'h5A);
        op(1'b1, 32'h0000_0101, 8'h3C);
        op(1'b0, 32'h0001_FFFF, 8'h00);
        check("ram_rd_top", {24'h0, data_from_ram}, 32'h5A);
        op(1'b0, 32'h0000_0100, 8'h00);
        check("ram_rd_keep", {24'h0, data_from_ram}, 32'hA5);
        rdy = 1'b0;
        op(1'b0, 32'h0000_0101, 8'h00);
        check("ram_freeze", {24'h0, data_from_ram}, 32'hA5);
        rdy = 1'b1;
        op(1'b0, 32'h0000_0101, 8'h00);
        check("ram_rd_101", {24'h0, data_from_ram}, 32'h3C);
        op(1'b0, 32'h0003_0008, 8'h00);
        check("io_rd_other", {24'h0, data_from_ram}, 32'h00);

`ifdef IO_RX_EN
        rx_valid = 1'b1; rx_data = 8'h42;
        op(1'b0, 32'h0000_0000, 8'h00);
        rx_valid = 1'b0;
        check("rx_held_rdy", {31'h0, rx_ready}, 32'h0);
        op(1'b0, c_io, 8'h00);
        check("rx_rd_42",    {24'h0, data_from_ram}, 32'h42);
        check("rx_rdy_back", {31'h0, rx_ready}, 32'h1);
        op(1'b0, c_io, 8'h00);
        check("rx_rd_empty", {24'h0, data_from_ram}, 32'h00);
        rx_valid = 1'b1; rx_data = 8'h77;
        op(1'b0, c_io, 8'h00);
        rx_valid = 1'b0;
        check("rx_same_cyc", {24'h0, data_from_ram}, 32'h00);
        check("rx_same_rdy", {31'h0, rx_ready}, 32'h0);
        op(1'b0, c_io, 8'h00);
        check("rx_rd_77",    {24'h0, data_from_ram}, 32'h77);
`else
        op(1'b0, 32'h0000_0100, 8'h00);
        rx_valid = 1'b1; rx_data = 8'h42;
        op(1'b0, c_io, 8'h00);
        rx_valid = 1'b0;
        check("rx_off_rd",  {24'h0, data_from_ram}, 32'h00);
        check("rx_off_rdy", {31'h0, rx_ready}, 32'h0);
`endif

        // TX FIFO fill, near-full, overflow drop, push+pop at full, drain order
        tx_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            op(1'b1, c_io, 8'h11 + 8'(i));
            check($sformatf("near_full_%0d", i + 1), {31'h0, uart_full_sign}, (i == 6) ? 32'h1 : 32'h0);
        end
        check("tx_head_11", {24'h0, tx_data}, 32'h11);
        check("tx_valid_1", {31'h0, tx_valid}, 32'h1);
        op(1'b1, c_io, 8'h18);
        op(1'b1, c_io, 8'h99);
        check("full_flag", {31'h0, uart_full_sign}, 32'h1);
        tx_ready = 1'b1;
        op(1'b1, c_io, 8'h19);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_%0d", i), {24'h0, tx_data}, 32'h12 + i);
            op(1'b0, 32'h0000_0000, 8'h00);
        end
        check("drained_txv",  {31'h0, tx_valid}, 32'h0);
        check("drained_full", {31'h0, uart_full_sign}, 32'h0);

        // Freeze with pending handshake, store and halt attempts
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) op(1'b1, c_io, 8'h21 + 8'(i));
        rdy = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op(1'b1, (i == 0) ? c_io + 32'd4 : c_io, 8'h25);
            check($sformatf("frz_head_%0d", i), {24'h0, tx_data}, 32'h21);
            check($sformatf("frz_halt_%0d", i), {31'h0, halt}, 32'h0);
        end
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("frz_drain_%0d", i), {24'h0, tx_data}, 32'h21 + i);
            op(1'b0, 32'h0000_0000, 8'h00);
        end
        check("frz_empty", {31'h0, tx_valid}, 32'h0);

        // Halt decode and asynchronous reset mid-drain
        tx_ready = 1'b0;
        op(1'b1, c_io + 32'd8, 8'h44);
        check("halt_other", {31'h0, halt}, 32'h0);
        check("other_nopush", {31'h0, tx_valid}, 32'h0);
        op(1'b1, c_io + 32'd4, 8'h00);
        check("halt_set", {31'h0, halt}, 32'h1);
        op(1'b1, c_io, 8'h31);
        op(1'b1, c_io, 8'h32);
        op(1'b0, 32'h0000_0000, 8'h00);
        tx_ready = 1'b1;
        op(1'b0, 32'h0000_0000, 8'h00);
        check("pre_rst_head", {24'h0, tx_data}, 32'h32);
        check("pre_rst_data", {24'h0, data_from_ram}, 32'hC3);
        check("halt_sticky",  {31'h0, halt}, 32'h1);
        rst = 1'b0;
        #1;
        check("arst_txv",  {31'h0, tx_valid}, 32'h0);
        check("arst_halt", {31'h0, halt}, 32'h0);
        check("arst_data", {24'h0, data_from_ram}, 32'h00);
        check("arst_full", {31'h0, uart_full_sign}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        op(1'b0, 32'h0000_0100, 8'h00);
        check("post_rst_rd", {24'h0, data_from_ram}, 32'hA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
